meas_update_scheduler: RTL and testbench
========================================

MEAS_UPDATE_SCHEDULER -- requirements
Module: meas_update_scheduler

Interface
REQ-001 SHALL have parameter NCH, default 13: number of measurement channels.
REQ-002 SHALL have parameter TIMEOUT, default 64: max cycles waited for converter done.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ch_data  input  16*NCH  raw binary sample per channel, channel i at bits [16i+15:16i].
REQ-006 ch_valid  input  NCH  one-cycle new-sample strobe per channel.
REQ-007 vblnk_in  input  1  vertical blank from the VGA timing chain.
REQ-008 conv_start  output  1  one-cycle request to the shared binary-to-BCD converter.
REQ-009 conv_bin  output  16  operand for the converter, stable from conv_start until done or timeout.
REQ-010 conv_done  input  1  one-cycle converter completion strobe.
REQ-011 conv_bcd  input  16  converter result, valid while conv_done is high.
REQ-012 bcd_bank  output  16*NCH  display-side BCD words, same packing as ch_data.
REQ-013 frame_updated  output  1  one-cycle pulse when a commit changed bcd_bank.
REQ-014 timeout_err  output  NCH  sticky per-channel converter-timeout flags.

Function
REQ-015 SHALL keep a pending bit per channel: set on ch_valid, cleared when the channel is granted; ch_valid on the same cycle as grant of that channel leaves pending set.
REQ-016 SHALL run FSM IDLE -> ISSUE -> WAIT -> STORE -> IDLE.
REQ-017 IDLE: if any pending, grant the first pending channel searching from rr_ptr upward with wrap NCH-1 -> 0, capture its ch_data into conv_bin, go ISSUE; else stay.
REQ-018 ISSUE: assert conv_start exactly one cycle, go WAIT.
REQ-019 WAIT: on conv_done go STORE with conv_bcd captured; after TIMEOUT cycles without conv_done set timeout_err[ch], leave shadow unchanged, go IDLE.
REQ-020 STORE: write shadow[ch], set dirty[ch], clear timeout_err not (sticky), go IDLE.
REQ-021 rr_ptr SHALL advance to (granted ch + 1) mod NCH on leaving WAIT (done or timeout).
REQ-022 conv_done outside WAIT SHALL be ignored.
REQ-023 Commit: on the cycle after a vblnk_in rising edge, if any dirty bit set, copy shadow to bcd_bank, clear all dirty, pulse frame_updated; else no change, no pulse.
REQ-024 A STORE on the commit cycle SHALL be excluded from that commit, keep its dirty bit, appear next frame.
REQ-025 bcd_bank SHALL change only at commit; never mid-frame.
REQ-026 Minimum latency ch_valid to conv_start: 3 cycles (pending, IDLE grant, ISSUE).

Reset
REQ-027 Asserted rst SHALL immediately force: FSM IDLE, pending/dirty/timeout_err 0, rr_ptr 0, conv_start 0, conv_bin 0, shadow and bcd_bank 0, frame_updated 0, vblnk edge register 0.
REQ-028 Reset mid-conversion SHALL abandon it; a late conv_done after release is ignored per REQ-022.

Structure
REQ-029 Shared package/include SHALL hold NCH default, word width 16, FSM state encoding.
REQ-030 Round-robin grant logic SHALL be sub-module meas_rr_arbiter (pending, rr_ptr in; grant index, any out).

Verification
REQ-031 ch_valid[3] with ch_data ch3=16'd1234, converter returns 16'h1234 after 5 cycles -> conv_start 3 cycles after strobe, conv_bin=1234; bcd_bank ch3=16'h1234 only after next vblnk rise, frame_updated one pulse.
REQ-032 ch_valid all 13 same cycle -> grant order 0,1,...,12; then ch_valid[12] and [0] together with rr_ptr=0... from rr_ptr=5 pending {2,7} -> grant 7 then 2.
REQ-033 Converter silent -> timeout_err[ch] set after 64 WAIT cycles, shadow unchanged, next pending channel served.
REQ-034 STORE coincident with commit cycle -> that value absent from bank this frame, committed at following vblnk rise.
REQ-035 rst low during WAIT, release, conv_done pulse -> no shadow write, all outputs zero.
REQ-036 vblnk rise with no dirty bits -> bcd_bank unchanged, no frame_updated.

Source files
------------

// File: rtl/meas_update_scheduler_pkg.sv
// Shared constants and FSM encoding for the measurement-to-BCD update scheduler.
package meas_update_scheduler_pkg;

  localparam int NCH_DEFAULT = 13;
  localparam int WORD_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STORE = 2'd3
  } state_e;

  // Index width that stays legal for degenerate one-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/meas_update_scheduler_rr_arbiter.sv
// Round-robin pick: first pending channel at or above rr_ptr, wrapping to 0.
module meas_rr_arbiter
  import meas_update_scheduler_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT,
  parameter int PW  = idx_w(NCH)
) (
  input  logic [NCH-1:0] pending,
  input  logic [PW-1:0]  rr_ptr,
  output logic [PW-1:0]  grant_idx,
  output logic           any
);

  int idx;

  // Scan from the farthest offset down so the nearest pending channel wins.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NCH;
      if (pending[idx]) begin
        grant_idx = PW'(idx);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/meas_update_scheduler.sv
// Serialises per-channel samples through one shared binary-to-BCD converter
// and publishes the results to the display bank only at vertical blank.
module meas_update_scheduler
  import meas_update_scheduler_pkg::*;
#(
  parameter int NCH     = NCH_DEFAULT,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WORD_W*NCH-1:0]   ch_data,
  input  logic [NCH-1:0]          ch_valid,
  input  logic                    vblnk_in,
  output logic                    conv_start,
  output logic [WORD_W-1:0]       conv_bin,
  input  logic                    conv_done,
  input  logic [WORD_W-1:0]       conv_bcd,
  output logic [WORD_W*NCH-1:0]   bcd_bank,
  output logic                    frame_updated,
  output logic [NCH-1:0]          timeout_err,
  output logic [1:0]              dbg_state
);

  localparam int PW = idx_w(NCH);
  localparam int CW = idx_w(TIMEOUT);
  localparam logic [NCH-1:0] BIT0 = NCH'(1);

  state_e                  state_q, state_d;
  logic [NCH-1:0]          pending_q, pending_d;
  logic [NCH-1:0]          dirty_q, dirty_d;
  logic [NCH-1:0]          timeout_err_q, timeout_err_d;
  logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]           ch_q, ch_d;
  logic [WORD_W-1:0]       conv_bin_q, conv_bin_d;
  logic [WORD_W-1:0]       res_q, res_d;
  logic [CW-1:0]           wait_cnt_q, wait_cnt_d;
  logic [WORD_W*NCH-1:0]   shadow_q, shadow_d;
  logic [WORD_W*NCH-1:0]   bank_q, bank_d;
  logic                    conv_start_q, conv_start_d;
  logic                    frame_updated_q, frame_updated_d;
  logic                    vblnk_q, vblnk_d;
  logic [PW-1:0]           grant_idx;
  logic                    grant_any;
  logic                    commit;
  logic [PW-1:0]           next_ptr;

  meas_rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
    .pending   (pending_q),
    .rr_ptr    (rr_ptr_q),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign next_ptr = (ch_q == PW'(NCH - 1)) ? '0 : ch_q + 1'b1;

  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q | ch_valid;
    dirty_d         = dirty_q;
    timeout_err_d   = timeout_err_q;
    rr_ptr_d        = rr_ptr_q;
    ch_d            = ch_q;
    conv_bin_d      = conv_bin_q;
    res_d           = res_q;
    wait_cnt_d      = wait_cnt_q;
    shadow_d        = shadow_q;
    bank_d          = bank_q;
    conv_start_d    = 1'b0;
    frame_updated_d = 1'b0;
    vblnk_d         = vblnk_in;
    commit          = vblnk_in & ~vblnk_q;

    // Commit copies the pre-edge shadow, so a same-cycle STORE lands next frame.
    if (commit && (|dirty_q)) begin
      bank_d          = shadow_q;
      dirty_d         = '0;
      frame_updated_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          pending_d  = (pending_q & ~(BIT0 << grant_idx)) | ch_valid;
          ch_d       = grant_idx;
          conv_bin_d = ch_data[grant_idx*WORD_W +: WORD_W];
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        conv_start_d = 1'b1;
        wait_cnt_d   = '0;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (conv_done) begin
          res_d    = conv_bcd;
          rr_ptr_d = next_ptr;
          state_d  = ST_STORE;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_err_d[ch_q] = 1'b1;
          rr_ptr_d            = next_ptr;
          state_d             = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_STORE: begin
        shadow_d[ch_q*WORD_W +: WORD_W] = res_q;
        dirty_d[ch_q]                   = 1'b1;
        state_d                         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      pending_q       <= '0;
      dirty_q         <= '0;
      timeout_err_q   <= '0;
      rr_ptr_q        <= '0;
      ch_q            <= '0;
      conv_bin_q      <= '0;
      res_q           <= '0;
      wait_cnt_q      <= '0;
      shadow_q        <= '0;
      bank_q          <= '0;
      conv_start_q    <= 1'b0;
      frame_updated_q <= 1'b0;
      vblnk_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      dirty_q         <= dirty_d;
      timeout_err_q   <= timeout_err_d;
      rr_ptr_q        <= rr_ptr_d;
      ch_q            <= ch_d;
      conv_bin_q      <= conv_bin_d;
      res_q           <= res_d;
      wait_cnt_q      <= wait_cnt_d;
      shadow_q        <= shadow_d;
      bank_q          <= bank_d;
      conv_start_q    <= conv_start_d;
      frame_updated_q <= frame_updated_d;
      vblnk_q         <= vblnk_d;
    end
  end

  assign conv_start    = conv_start_q;
  assign conv_bin      = conv_bin_q;
  assign bcd_bank      = bank_q;
  assign frame_updated = frame_updated_q;
  assign timeout_err   = timeout_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_meas_update_scheduler.sv
// Bench for meas_update_scheduler: directed scenarios plus randomized traffic
// checked against a transaction-level model of grants, shadow and bank.
module tb_meas_update_scheduler;
  import meas_update_scheduler_pkg::*;

  localparam int NCH = 13;
  localparam int TMO = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic [16*NCH-1:0]   ch_data;
  logic [NCH-1:0]      ch_valid;
  logic                vblnk_in;
  logic                conv_start;
  logic [15:0]         conv_bin;
  logic                conv_done;
  logic [15:0]         conv_bcd;
  logic [16*NCH-1:0]   bcd_bank;
  logic                frame_updated;
  logic [NCH-1:0]      timeout_err;
  logic [1:0]          dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [15:0]    data_m[NCH];
  logic [15:0]    shadow_m[NCH];
  logic [15:0]    bank_m[NCH];
  logic [NCH-1:0] pend_m, dirty_m, terr_m;
  int             rr_m;

  meas_update_scheduler #(.NCH(NCH), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .ch_data       (ch_data),
    .ch_valid      (ch_valid),
    .vblnk_in      (vblnk_in),
    .conv_start    (conv_start),
    .conv_bin      (conv_bin),
    .conv_done     (conv_done),
    .conv_bcd      (conv_bcd),
    .bcd_bank      (bcd_bank),
    .frame_updated (frame_updated),
    .timeout_err   (timeout_err),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16*NCH-1:0] pack(input logic [15:0] a[NCH]);
    logic [16*NCH-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i*16 +: 16] = a[i];
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input logic [15:0] v);
    int x;
    x = int'(v) % 10000;
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  function automatic int pick(input logic [NCH-1:0] p, input int rr);
    for (int i = 0; i < NCH; i++)
      if (p[(rr + i) % NCH]) return (rr + i) % NCH;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      shadow_m[i] = '0;
      bank_m[i]   = '0;
    end
    pend_m = '0; dirty_m = '0; terr_m = '0; rr_m = 0;
  endtask

  task automatic drive_valid(input logic [NCH-1:0] m);
    for (int i = 0; i < NCH; i++)
      if (m[i]) data_m[i] = 16'($urandom_range(0, 9999));
    ch_data  = pack(data_m);
    ch_valid = m;
    pend_m   = pend_m | m;
  endtask

  task automatic pulse(input logic [NCH-1:0] m);
    drive_valid(m);
    tick();
    ch_valid = '0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (conv_start !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (conv_start !== 1'b1) begin
      chk("start_timeout", {255'd0, conv_start}, 256'd1);
      n = -1;
    end
  endtask

  // Serve one conversion as the converter; optional strobes while busy and
  // an optional vblank rise landing exactly on the STORE cycle.
  task automatic do_conv(input int delay, input bit silent, input logic [NCH-1:0] smask,
                         input bit vb_store);
    int n, ch;
    logic [15:0] exp_bin, bcd;
    bit fu_exp;
    wait_start(n);
    if (n < 0) return;
    ch = pick(pend_m, rr_m);
    if (ch < 0) ch = 0;
    exp_bin = data_m[ch];
    chk("conv_bin_grant", conv_bin, exp_bin);
    pend_m[ch] = 1'b0;
    if (smask != '0) drive_valid(smask);
    tick();
    ch_valid = '0;
    chk("start_one_cycle", conv_start, 0);
    rr_m = (ch + 1) % NCH;
    if (silent) begin
      repeat (TMO - 2) tick();
      chk("terr_not_early", timeout_err[ch], 0);
      tick();
      terr_m[ch] = 1'b1;
      chk("terr_set", timeout_err, terr_m);
      return;
    end
    repeat (delay - 1) tick();
    chk("bin_stable", conv_bin, exp_bin);
    bcd       = to_bcd(exp_bin);
    conv_done = 1'b1;
    conv_bcd  = bcd;
    tick();
    conv_done = 1'b0;
    conv_bcd  = 16'($urandom);
    fu_exp    = 1'b0;
    if (vb_store) begin
      vblnk_in = 1'b1;
      if (dirty_m != '0) begin
        bank_m  = shadow_m;
        dirty_m = '0;
        fu_exp  = 1'b1;
      end
    end
    shadow_m[ch] = bcd;
    dirty_m[ch]  = 1'b1;
    tick();
    if (vb_store) begin
      chk("store_commit_pulse", frame_updated, fu_exp);
      vblnk_in = 1'b0;
    end
    chk("bank_hold", bcd_bank, pack(bank_m));
    chk("terr_vec", timeout_err, terr_m);
  endtask

  task automatic do_vblank();
    bit fu_exp;
    tick();
    vblnk_in = 1'b1;
    chk("bank_pre_commit", bcd_bank, pack(bank_m));
    fu_exp = (dirty_m != '0);
    if (fu_exp) begin
      bank_m  = shadow_m;
      dirty_m = '0;
    end
    tick();
    chk("frame_pulse", frame_updated, fu_exp);
    chk("bank_commit", bcd_bank, pack(bank_m));
    tick();
    chk("frame_once", frame_updated, 0);
    vblnk_in = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0; ch_valid = '0; vblnk_in = 1'b0; conv_done = 1'b0; conv_bcd = '0;
    for (int i = 0; i < NCH; i++) data_m[i] = '0;
    ch_data = '0;
    model_reset();
    #1;
    chk("rst_start", conv_start, 0);
    chk("rst_bin", conv_bin, 0);
    chk("rst_bank", bcd_bank, 0);
    chk("rst_fu", frame_updated, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Single sample on channel 3: three-cycle latency, bank only at vblank
    data_m[3] = 16'd1234;
    ch_data   = pack(data_m);
    ch_valid  = 13'h008;
    pend_m[3] = 1'b1;
    tick();
    ch_valid = '0;
    chk("lat_c1", conv_start, 0);
    tick();
    chk("lat_c2", conv_start, 0);
    tick();
    chk("lat_c3", conv_start, 1);
    chk("bin_1234", conv_bin, 16'd1234);
    do_conv(5, 1'b0, '0, 1'b0);
    do_vblank();
    chk("bank_ch3", bcd_bank[63:48], 16'h1234);

    // All channels at once, then wrap and mid-range round-robin cases
    pulse(13'h1FFF);
    for (int i = 0; i < NCH; i++) do_conv($urandom_range(1, 4), 1'b0, '0, 1'b0);
    pulse(13'h1001);
    do_conv(2, 1'b0, '0, 1'b0);
    do_conv(2, 1'b0, '0, 1'b0);
    pulse(13'h0010);
    do_conv(1, 1'b0, '0, 1'b0);
    pulse(13'h0084);
    do_conv(3, 1'b0, '0, 1'b0);
    do_conv(3, 1'b0, '0, 1'b0);
    do_vblank();

    // Re-strobe on the grant cycle keeps the channel pending
    drive_valid(13'h0040);
    tick();
    ch_valid = 13'h0040;
    tick();
    ch_valid = '0;
    do_conv(2, 1'b0, '0, 1'b0);
    pend_m[6] = 1'b1;
    do_conv(2, 1'b0, '0, 1'b0);

    // Silent converter on channel 9, channel 10 served afterwards
    pulse(13'h0600);
    do_conv(1, 1'b1, '0, 1'b0);
    do_conv(2, 1'b0, '0, 1'b0);
    do_vblank();

    // STORE coincident with commit: ch1 commits, ch5 waits a frame
    pulse(13'h0002);
    do_conv(2, 1'b0, '0, 1'b0);
    pulse(13'h0020);
    do_conv(2, 1'b0, '0, 1'b1);
    do_vblank();

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      if (pend_m == '0) begin
        if ($urandom_range(0, 2) == 0) do_vblank();
        pulse(13'($urandom_range(1, 8191)));
      end
      do_conv($urandom_range(1, 6), 1'b0,
              ($urandom_range(0, 1) == 1) ? 13'($urandom_range(0, 8191)) : 13'd0, 1'b0);
    end
    while (pend_m != '0) do_conv($urandom_range(1, 3), 1'b0, '0, 1'b0);
    do_vblank();

    // Vblank with nothing dirty
    do_vblank();

    // Reset while waiting on the converter, then a late done
    pulse(13'h0004);
    wait_start(n);
    tick(); tick();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rstw_start", conv_start, 0);
    chk("rstw_bin", conv_bin, 0);
    chk("rstw_bank", bcd_bank, 0);
    chk("rstw_fu", frame_updated, 0);
    chk("rstw_terr", timeout_err, 0);
    chk("rstw_state", dbg_state, ST_IDLE);
    tick();
    rst = 1'b1;
    tick();
    conv_done = 1'b1;
    conv_bcd  = 16'h9999;
    tick();
    conv_done = 1'b0;
    tick(); tick();
    chk("late_done_start", conv_start, 0);
    chk("late_done_state", dbg_state, ST_IDLE);
    chk("late_done_bank", bcd_bank, 0);
    do_vblank();
    pulse(13'h0002);
    do_conv(2, 1'b0, '0, 1'b0);
    do_vblank();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
